debug_regfile_controller: RTL and testbench
===========================================

Name: debug_regfile_controller

Overview:
- Debug sequencer for the MIPS core's register file and pipeline enable.
- Halts or runs the core, single-steps it, and dumps all architectural registers byte-serially to the UART TX path.
- During a dump it drives the register file debug read port and holds `debug_on` high, which blocks register-file writeback.
- Sits between the debug command decoder (UART RX side) and the CPU top.

Parameters:
- NUM_REGS, 32, number of registers dumped (addresses 0..NUM_REGS-1).
- READ_LAT, 1, cycles from `dbg_read_reg` change to valid `dbg_reg_data` (1..3).
- HEADER_BYTE, 8'hA5, byte sent before register data in every dump.
- START_HALTED, 1, 1 = the state after reset is HALT; 0 = RUN.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- halt_req  in  1  single-cycle pulse: stop the core.
- run_req  in  1  single-cycle pulse: free-run the core.
- step_req  in  1  single-cycle pulse: advance the core one clock.
- dump_req  in  1  single-cycle pulse: dump the register file.
- dbg_reg_data  in  32  register file debug read data.
- tx_ready  in  1  UART TX accepts a byte.
- cpu_enable  out  1  pipeline clock-enable (PC/IF/ID/EX/MEM/WB advance).
- debug_on  out  1  selects the debug read port and blocks regfile writes.
- dbg_read_reg  out  5  register file debug read address.
- tx_data  out  8  byte to transmit.
- tx_valid  out  1  tx_data valid.
- busy  out  1  high in STEP, LOAD, SEND_HDR and SEND.
- halted  out  1  high in every state except RUN.

Behaviour:
- Reset (async): state = HALT if START_HALTED else RUN.
  - cpu_enable = !START_HALTED; debug_on = 0; dbg_read_reg = 0; tx_data = 0; tx_valid = 0; busy = 0; halted = START_HALTED.
  - Byte index and wait counter cleared.
- States: RUN, HALT, STEP, SEND_HDR, LOAD, SEND.
- RUN: cpu_enable = 1, debug_on = 0.
  - halt_req -> HALT; cpu_enable drops in the cycle after the pulse is sampled.
  - All other requests ignored.
- HALT: cpu_enable = 0, debug_on = 0.
  - Simultaneous-request priority: dump_req > step_req > run_req; halt_req is ignored.
  - dump_req -> SEND_HDR; run_req -> RUN; step_req -> STEP.
- STEP: cpu_enable = 1 for exactly one cycle, then -> HALT.
  - Requests arriving in STEP are dropped, not queued.
- SEND_HDR: debug_on = 1, tx_data = HEADER_BYTE, tx_valid = 1.
  - On tx_valid && tx_ready -> LOAD with dbg_read_reg = 0.
- LOAD: debug_on = 1, tx_valid = 0.
  - Waits READ_LAT cycles, then latches dbg_reg_data into a 32-bit shift register, sets byte index = 0, -> SEND.
- SEND: tx_data = shift[31:24] (MSB first), tx_valid = 1.
  - Each handshake (tx_valid && tx_ready) shifts left by 8 and increments the byte index.
  - After byte 3 is accepted:
    - if dbg_read_reg == NUM_REGS-1 -> HALT, debug_on = 0, dbg_read_reg = 0;
    - else dbg_read_reg + 1 -> LOAD.
- Handshake rules:
  - Once tx_valid is high, tx_data is stable and tx_valid stays high until accepted.
  - tx_ready held high gives one byte per cycle in SEND; there is a READ_LAT-cycle gap per register.
  - tx_ready low stalls indefinitely with no data loss and no timeout.
- debug_on is high for the entire dump and for no other state; cpu_enable is 0 throughout the dump.
- Total dump = 1 + 4*NUM_REGS bytes (129 at default).
- All requests, including halt_req, are ignored while busy = 1.
- Reset mid-dump aborts immediately to the reset state. No partial-byte completion; tx_valid deasserts asynchronously.
- busy and halted are registered, derived from the state encoding, and glitch-free.

Test Plan:
- Reset with START_HALTED = 1, then run_req pulse -> cpu_enable = 1 from the following cycle, halted = 0; halt_req pulse -> cpu_enable = 0 next cycle, halted = 1.
- Halted, step_req pulse three times (spaced) -> exactly 3 cycles of cpu_enable = 1, each 1 cycle wide; the core PC advances by 3 instructions.
- Regfile loaded with reg[i] = 32'h1000_0000 + i, dump_req, tx_ready held 1 -> bytes A5, 10,00,00,00, 10,00,00,01, ..., 10,00,00,1F (129 bytes); debug_on high throughout; ends in HALT.
- Same dump with tx_ready toggling at random (~30% high) -> identical 129-byte sequence; tx_data never changes while tx_valid && !tx_ready.
- dump_req, step_req and run_req in the same cycle while halted -> dump starts; no step occurs; state returns to HALT after the dump, not RUN.
- Assert rst after byte 50 of a dump -> tx_valid and debug_on are 0 within the reset cycle, state is HALT; a fresh dump_req restarts at HEADER_BYTE, register 0.

Source files
------------

// File: rtl/debug_regfile_controller.sv
// Debug sequencer for the MIPS core: halts, runs and single-steps the pipeline,
// and streams the whole register file out over the UART TX byte interface.
module debug_regfile_controller #(
    parameter int         NUM_REGS     = 32,
    parameter int         READ_LAT     = 1,
    parameter logic [7:0] HEADER_BYTE  = 8'hA5,
    parameter bit         START_HALTED = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        halt_req,
    input  logic        run_req,
    input  logic        step_req,
    input  logic        dump_req,
    input  logic [31:0] dbg_reg_data,
    input  logic        tx_ready,
    output logic        cpu_enable,
    output logic        debug_on,
    output logic [4:0]  dbg_read_reg,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        busy,
    output logic        halted
);

    typedef enum logic [2:0] {
        ST_RUN,
        ST_HALT,
        ST_STEP,
        ST_SEND_HDR,
        ST_LOAD,
        ST_SEND
    } state_t;

    localparam logic [4:0] LAST_REG  = 5'(NUM_REGS - 1);
    localparam logic [1:0] WAIT_LAST = 2'(READ_LAT - 1);

    state_t      state;
    logic [31:0] shift;
    logic [1:0]  byte_idx;
    logic [1:0]  wait_cnt;

    // The outgoing byte is always the top of the shift register, so the header
    // is simply preloaded there; tx_data is therefore a plain register output.
    assign tx_data = shift[31:24];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= START_HALTED ? ST_HALT : ST_RUN;
            cpu_enable   <= !START_HALTED;
            debug_on     <= 1'b0;
            dbg_read_reg <= '0;
            tx_valid     <= 1'b0;
            busy         <= 1'b0;
            halted       <= START_HALTED;
            shift        <= '0;
            byte_idx     <= '0;
            wait_cnt     <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (halt_req) begin
                        state      <= ST_HALT;
                        cpu_enable <= 1'b0;
                        halted     <= 1'b1;
                    end
                end
                ST_HALT: begin
                    if (dump_req) begin
                        state        <= ST_SEND_HDR;
                        debug_on     <= 1'b1;
                        dbg_read_reg <= '0;
                        shift        <= {HEADER_BYTE, 24'h000000};
                        tx_valid     <= 1'b1;
                        busy         <= 1'b1;
                    end else if (step_req) begin
                        state      <= ST_STEP;
                        cpu_enable <= 1'b1;
                        busy       <= 1'b1;
                    end else if (run_req) begin
                        state      <= ST_RUN;
                        cpu_enable <= 1'b1;
                        halted     <= 1'b0;
                    end
                end
                ST_STEP: begin
                    state      <= ST_HALT;
                    cpu_enable <= 1'b0;
                    busy       <= 1'b0;
                end
                ST_SEND_HDR: begin
                    if (tx_valid && tx_ready) begin
                        state        <= ST_LOAD;
                        tx_valid     <= 1'b0;
                        shift        <= '0;
                        dbg_read_reg <= '0;
                        wait_cnt     <= '0;
                    end
                end
                ST_LOAD: begin
                    if (wait_cnt == WAIT_LAST) begin
                        state    <= ST_SEND;
                        shift    <= dbg_reg_data;
                        tx_valid <= 1'b1;
                        byte_idx <= '0;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                ST_SEND: begin
                    if (tx_valid && tx_ready) begin
                        shift    <= {shift[23:0], 8'h00};
                        byte_idx <= byte_idx + 2'd1;
                        // Fourth byte of this register accepted: next register or done
                        if (byte_idx == 2'd3) begin
                            tx_valid <= 1'b0;
                            if (dbg_read_reg == LAST_REG) begin
                                state        <= ST_HALT;
                                debug_on     <= 1'b0;
                                busy         <= 1'b0;
                                dbg_read_reg <= '0;
                            end else begin
                                state        <= ST_LOAD;
                                dbg_read_reg <= dbg_read_reg + 5'd1;
                                wait_cnt     <= '0;
                            end
                        end
                    end
                end
                default: begin
                    state      <= ST_HALT;
                    cpu_enable <= 1'b0;
                    debug_on   <= 1'b0;
                    tx_valid   <= 1'b0;
                    busy       <= 1'b0;
                    halted     <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debug_regfile_controller.sv
// Randomized self-checking bench for debug_regfile_controller: run/halt/step
// control and full register dumps checked against a byte-level reference model.
module tb_debug_regfile_controller;

    localparam int         NUM_REGS = 32;
    localparam int         READ_LAT = 1;
    localparam logic [7:0] HDR      = 8'hA5;
    localparam int         DUMP_LEN = 1 + 4 * NUM_REGS;

    logic        clk;
    logic        rst;
    logic        halt_req, run_req, step_req, dump_req;
    logic [31:0] dbg_reg_data;
    logic        tx_ready;
    logic        cpu_enable, debug_on, tx_valid, busy, halted;
    logic [4:0]  dbg_read_reg;
    logic [7:0]  tx_data;

    logic [31:0] regs [NUM_REGS];
    int          pc = 0;
    int          assertions = 0;
    int          failures = 0;

    debug_regfile_controller #(
        .NUM_REGS(NUM_REGS), .READ_LAT(READ_LAT), .HEADER_BYTE(HDR), .START_HALTED(1'b1)
    ) dut (
        .clk(clk), .rst(rst),
        .halt_req(halt_req), .run_req(run_req), .step_req(step_req), .dump_req(dump_req),
        .dbg_reg_data(dbg_reg_data), .tx_ready(tx_ready),
        .cpu_enable(cpu_enable), .debug_on(debug_on), .dbg_read_reg(dbg_read_reg),
        .tx_data(tx_data), .tx_valid(tx_valid), .busy(busy), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file debug port: data for the presented address is valid by the next edge
    assign dbg_reg_data = regs[dbg_read_reg];

    always @(posedge clk) if (cpu_enable) pc <= pc + 1;

    task automatic pulse(input bit h, input bit r, input bit s, input bit d);
        @(posedge clk); #1;
        halt_req = h; run_req = r; step_req = s; dump_req = d;
        @(posedge clk); #1;
        halt_req = 0; run_req = 0; step_req = 0; dump_req = 0;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        assertions++;
        if (cpu_enable !== 1'b0 || halted !== 1'b1 || busy !== 1'b0 || debug_on !== 1'b0 ||
            tx_valid !== 1'b0 || dbg_read_reg !== 5'd0 || tx_data !== 8'h00) begin
            failures++;
            $display("[TB] FAIL reset_state: en=%b halted=%b busy=%b dbg=%b valid=%b reg=%0d data=%h, required 0 1 0 0 0 0 00",
                     cpu_enable, halted, busy, debug_on, tx_valid, dbg_read_reg, tx_data);
        end
        rst = 1'b0;
    endtask

    task automatic test_run_halt;
        pulse(0, 1, 0, 0);
        assertions++;
        if (cpu_enable !== 1'b1 || halted !== 1'b0) begin
            failures++;
            $display("[TB] FAIL run_req: en=%b halted=%b, required 1 0", cpu_enable, halted);
        end
        pulse(0, 0, 1, 1);
        assertions++;
        if (cpu_enable !== 1'b1 || busy !== 1'b0 || debug_on !== 1'b0 || halted !== 1'b0) begin
            failures++;
            $display("[TB] FAIL run_ignores_reqs: en=%b busy=%b dbg=%b halted=%b, required 1 0 0 0",
                     cpu_enable, busy, debug_on, halted);
        end
        pulse(1, 0, 0, 0);
        assertions++;
        if (cpu_enable !== 1'b0 || halted !== 1'b1) begin
            failures++;
            $display("[TB] FAIL halt_req: en=%b halted=%b, required 0 1", cpu_enable, halted);
        end
    endtask

    task automatic test_step;
        int pc0;
        pc0 = pc;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            step_req = 1;
            @(posedge clk); #1;
            step_req = 0;
            assertions++;
            if (cpu_enable !== 1'b1 || busy !== 1'b1 || halted !== 1'b1) begin
                failures++;
                $display("[TB] FAIL step_%0d_on: en=%b busy=%b halted=%b, required 1 1 1",
                         i, cpu_enable, busy, halted);
            end
            if (i == 1) run_req = 1;
            @(posedge clk); #1;
            run_req = 0;
            assertions++;
            if (cpu_enable !== 1'b0 || busy !== 1'b0 || halted !== 1'b1) begin
                failures++;
                $display("[TB] FAIL step_%0d_off: en=%b busy=%b halted=%b, required 0 0 1",
                         i, cpu_enable, busy, halted);
            end
            repeat (3) @(posedge clk);
            #1;
        end
        assertions++;
        if (pc - pc0 !== 3) begin
            failures++;
            $display("[TB] FAIL step_pc_advance: got %0d, required 3", pc - pc0);
        end
    endtask

    task automatic test_random_requests;
        bit mode_run, h, r, s, e1, e2, nb, nxt;
        mode_run = 0;
        for (int i = 0; i < 24; i++) begin
            h = 1'($urandom); r = 1'($urandom); s = 1'($urandom);
            if (mode_run) begin
                e1 = !h; e2 = !h; nb = 0; nxt = !h;
            end else if (s) begin
                e1 = 1; e2 = 0; nb = 1; nxt = 0;
            end else if (r) begin
                e1 = 1; e2 = 1; nb = 0; nxt = 1;
            end else begin
                e1 = 0; e2 = 0; nb = 0; nxt = 0;
            end
            pulse(h, r, s, 0);
            assertions++;
            if (cpu_enable !== e1 || busy !== nb) begin
                failures++;
                $display("[TB] FAIL rand_req_%0d_first: en=%b busy=%b, required %b %b (h%b r%b s%b)",
                         i, cpu_enable, busy, e1, nb, h, r, s);
            end
            @(posedge clk); #1;
            assertions++;
            if (cpu_enable !== e2 || halted !== !nxt) begin
                failures++;
                $display("[TB] FAIL rand_req_%0d_second: en=%b halted=%b, required %b %b",
                         i, cpu_enable, halted, e2, !nxt);
            end
            mode_run = nxt;
        end
        if (mode_run) pulse(1, 0, 0, 0);
    endtask

    task automatic run_dump(input int ready_pct, input bit collide, input int abort_after);
        logic [7:0] exp_q[$];
        logic [7:0] held;
        int got, cycles, pc0;
        bit stalled;
        exp_q.push_back(HDR);
        for (int i = 0; i < NUM_REGS; i++)
            for (int b = 3; b >= 0; b--)
                exp_q.push_back(regs[i][8*b +: 8]);
        @(posedge clk); #1;
        dump_req = 1;
        if (collide) begin step_req = 1; run_req = 1; end
        @(posedge clk); #1;
        dump_req = 0; step_req = 0; run_req = 0;
        tx_ready = ($urandom_range(0, 99) < ready_pct);
        pc0 = pc;
        got = 0; cycles = 0; stalled = 0; held = 8'h00;
        while (got < DUMP_LEN && cycles < 20000) begin
            @(negedge clk);
            cycles++;
            assertions++;
            if (debug_on !== 1'b1 || cpu_enable !== 1'b0 || busy !== 1'b1 || halted !== 1'b1) begin
                failures++;
                $display("[TB] FAIL dump_ctrl cycle %0d: dbg=%b en=%b busy=%b halted=%b, required 1 0 1 1",
                         cycles, debug_on, cpu_enable, busy, halted);
            end
            if (stalled) begin
                assertions++;
                if (tx_valid !== 1'b1 || tx_data !== held) begin
                    failures++;
                    $display("[TB] FAIL stall_hold cycle %0d: valid=%b data=%h, required 1 %h",
                             cycles, tx_valid, tx_data, held);
                end
            end
            if (tx_valid === 1'b1 && tx_ready) begin
                assertions++;
                if (tx_data !== exp_q[got]) begin
                    failures++;
                    $display("[TB] FAIL dump_byte %0d: got %h, required %h", got, tx_data, exp_q[got]);
                end
                got++;
                stalled = 0;
            end else begin
                stalled = (tx_valid === 1'b1);
                held = tx_data;
            end
            if (abort_after > 0 && got == abort_after) break;
            @(posedge clk); #1;
            tx_ready = ($urandom_range(0, 99) < ready_pct);
        end
        if (abort_after == 0) begin
            tx_ready = 0;
            assertions++;
            if (got != DUMP_LEN) begin
                failures++;
                $display("[TB] FAIL dump_timeout: got %0d bytes, required %0d", got, DUMP_LEN);
            end
            assertions++;
            if (tx_valid !== 1'b0 || debug_on !== 1'b0 || busy !== 1'b0 || halted !== 1'b1 ||
                cpu_enable !== 1'b0 || dbg_read_reg !== 5'd0) begin
                failures++;
                $display("[TB] FAIL dump_end: valid=%b dbg=%b busy=%b halted=%b en=%b reg=%0d, required 0 0 0 1 0 0",
                         tx_valid, debug_on, busy, halted, cpu_enable, dbg_read_reg);
            end
            if (ready_pct == 100) begin
                assertions++;
                if (cycles != 1 + NUM_REGS * (READ_LAT + 4)) begin
                    failures++;
                    $display("[TB] FAIL dump_duration: got %0d cycles, required %0d",
                             cycles, 1 + NUM_REGS * (READ_LAT + 4));
                end
            end
            @(posedge clk); #1;
            assertions++;
            if (pc != pc0 || cpu_enable !== 1'b0 || halted !== 1'b1) begin
                failures++;
                $display("[TB] FAIL dump_after: pc_delta=%0d en=%b halted=%b, required 0 0 1",
                         pc - pc0, cpu_enable, halted);
            end
        end
    endtask

    task automatic test_dump_ready;
        for (int i = 0; i < NUM_REGS; i++) regs[i] = 32'h1000_0000 + i;
        run_dump(100, 0, 0);
    endtask

    task automatic test_dump_random_ready;
        run_dump(30, 0, 0);
        for (int i = 0; i < NUM_REGS; i++) regs[i] = $urandom;
        run_dump(30, 0, 0);
    endtask

    task automatic test_back_to_back_requests;
        for (int i = 0; i < NUM_REGS; i++) regs[i] = $urandom;
        run_dump(60, 1, 0);
    endtask

    task automatic test_reset_mid_dump;
        for (int i = 0; i < NUM_REGS; i++) regs[i] = $urandom;
        run_dump(50, 0, 50);
        @(posedge clk); #2;
        rst = 1;
        #1;
        assertions++;
        if (tx_valid !== 1'b0 || debug_on !== 1'b0 || halted !== 1'b1 || busy !== 1'b0 ||
            cpu_enable !== 1'b0 || dbg_read_reg !== 5'd0) begin
            failures++;
            $display("[TB] FAIL mid_dump_reset: valid=%b dbg=%b halted=%b busy=%b en=%b reg=%0d, required 0 0 1 0 0 0",
                     tx_valid, debug_on, halted, busy, cpu_enable, dbg_read_reg);
        end
        @(posedge clk); #1;
        rst = 0;
        tx_ready = 0;
        run_dump(100, 0, 0);
    endtask

    initial begin
        rst = 1;
        halt_req = 0; run_req = 0; step_req = 0; dump_req = 0;
        tx_ready = 0;
        for (int i = 0; i < NUM_REGS; i++) regs[i] = 32'h1000_0000 + i;
        $display("[TB] starting debug_regfile_controller bench");
        test_reset;
        test_run_halt;
        test_step;
        test_random_requests;
        test_dump_ready;
        test_dump_random_ready;
        test_back_to_back_requests;
        test_reset_mid_dump;
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
